// File: rtl/feat_ram_arb_pkg.sv
// Shared definitions for the feature RAM arbiter: the data and address widths,
// the requester indices, and the encoding of the round-robin pointer FSM.
package feat_ram_arb_pkg;

    // Feature RAM geometry. 238 of the 256 words are used.
    localparam int FEAT_DW = 96;
    localparam int FEAT_AW = 8;

    // Bit positions of the two readers in iRD_REQ, oRD_GNT and oRVALID.
    localparam int REQ_BWN = 0;
    localparam int REQ_BNN = 1;

    // One-hot requester tag. It is carried through the latency pipe so that
    // returning data can be steered to the reader that asked for it.
    typedef logic [1:0] reqTag_t;

    // Round-robin pointer: which reader wins when both request together.
    typedef enum logic {
        PRI_BWN = 1'b0,
        PRI_BNN = 1'b1
    } ptrState_t;

    // One-hot grant given to the prioritised reader in a given pointer state.
    function automatic reqTag_t priMask(input ptrState_t s);
        reqTag_t m;
        m = '0;
        if (s == PRI_BNN) begin
            m[REQ_BNN] = 1'b1;
        end else begin
            m[REQ_BWN] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/feat_ram_arb_rd_lat_pipe.sv
// Read-latency pipe: an RD_LAT-deep shift register carrying the grant tag
// alongside the RAM access, plus the output register that captures the RAM
// read data when the tag reaches the end of the pipe. The captured data is
// held while no read is returning.
module rd_lat_pipe
    import feat_ram_arb_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int DW     = FEAT_DW
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic [1:0]    iTag,
    input  logic [DW-1:0] iRdata,
    output logic [1:0]    oValid,
    output logic [DW-1:0] oData
);

    reqTag_t tagPipe [RD_LAT];
    reqTag_t tagOut;

    assign tagOut = tagPipe[RD_LAT-1];

    // Tag shift register; reset drops every in-flight read.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tagPipe[i] <= '0;
            end
        end else begin
            tagPipe[0] <= iTag;
            for (int i = 1; i < RD_LAT; i++) begin
                tagPipe[i] <= tagPipe[i-1];
            end
        end
    end

    // Output register: valid follows the tag, data only loads on a real return.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oValid <= '0;
            oData  <= '0;
        end else begin
            oValid <= tagOut;
            if (tagOut != '0) begin
                oData <= iRdata;
            end
        end
    end

endmodule

// File: rtl/feat_ram_arb.sv
// Feature RAM arbiter. The single-port 96-bit feature RAM is shared between
// the write controller (which never stalls and so always wins) and two read
// engines (BWN conv, BNN conv/FC) that share the remaining cycles round-robin
// with bounded bursts.
//
// Read handshake: a reader raises its iRD_REQ bit and holds it, together with
// its address, until it sees its oRD_GNT bit in the same cycle; the grant is
// the acceptance. Exactly RD_LAT+1 cycles after the grant the matching
// oRVALID bit pulses for one cycle with the word on oRDATA. Returns come back
// in grant order, one per cycle for back-to-back grants.
module feat_ram_arb
    import feat_ram_arb_pkg::*;
#(
    parameter int DW        = FEAT_DW,
    parameter int AW        = FEAT_AW,
    parameter int RD_LAT    = 1,
    parameter int BURST_MAX = 16
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iEN_WC,
    input  logic [AW-1:0] iWADDR,
    input  logic [DW-1:0] iWDATA,
    input  logic [1:0]    iRD_REQ,
    input  logic [AW-1:0] iRADDR_BWN,
    input  logic [AW-1:0] iRADDR_BNN,
    output logic [1:0]    oRD_GNT,
    output logic [1:0]    oRVALID,
    output logic [DW-1:0] oRDATA,
    output logic          oRAM_EN,
    output logic          oRAM_WE,
    output logic [AW-1:0] oRAM_ADDR,
    output logic [DW-1:0] oRAM_WDATA,
    input  logic [DW-1:0] iRAM_RDATA,
    output logic          oCOLLIDE
);

    // Burst counter counts contested grants 0..BURST_MAX-1.
    localparam int            CW         = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [CW-1:0] BURST_LAST = CW'(BURST_MAX - 1);

    ptrState_t     state;
    ptrState_t     stateNext;
    logic [CW-1:0] burstCnt;
    logic [CW-1:0] burstCntNext;
    reqTag_t       rdGnt;
    logic          rdBlocked;
    logic [7:0]    starveCnt;
    logic          collide;

    // Write data is always presented; the RAM only uses it when WE is high.
    assign oRAM_WDATA = iWDATA;
    assign oRD_GNT    = rdGnt;
    assign oCOLLIDE   = collide;

    // A read request is being held off by a write this cycle.
    assign rdBlocked = iEN_WC && (iRD_REQ != 2'b00);

    // Port arbitration: write first, then the pointer decides contested reads.
    always_comb begin
        rdGnt     = '0;
        oRAM_EN   = 1'b0;
        oRAM_WE   = 1'b0;
        oRAM_ADDR = iWADDR;
        if (iEN_WC) begin
            oRAM_EN   = 1'b1;
            oRAM_WE   = 1'b1;
            oRAM_ADDR = iWADDR;
        end else if (iRD_REQ != 2'b00) begin
            oRAM_EN = 1'b1;
            if (iRD_REQ == 2'b11) begin
                rdGnt = priMask(state);
            end else begin
                rdGnt = iRD_REQ;
            end
            oRAM_ADDR = rdGnt[REQ_BNN] ? iRADDR_BNN : iRADDR_BWN;
        end
    end

    // Pointer next state: bursts only count while both readers compete; a
    // lone grant to the other reader restarts the burst without moving the
    // pointer; cycles with no read grant change nothing.
    always_comb begin
        stateNext    = state;
        burstCntNext = burstCnt;
        if (rdGnt != '0) begin
            if (iRD_REQ == 2'b11) begin
                if (burstCnt == BURST_LAST) begin
                    stateNext    = (state == PRI_BWN) ? PRI_BNN : PRI_BWN;
                    burstCntNext = '0;
                end else begin
                    burstCntNext = burstCnt + 1'b1;
                end
            end else if (rdGnt != priMask(state)) begin
                burstCntNext = '0;
            end
        end
    end

    // Pointer and burst counter registers.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state    <= PRI_BWN;
            burstCnt <= '0;
        end else begin
            state    <= stateNext;
            burstCnt <= burstCntNext;
        end
    end

    // Starvation monitor: the 256th consecutive blocked cycle raises a sticky
    // flag. The count saturates so the flag condition stays stable.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            starveCnt <= '0;
            collide   <= 1'b0;
        end else if (rdBlocked) begin
            if (starveCnt == 8'hFF) begin
                collide <= 1'b1;
            end else begin
                starveCnt <= starveCnt + 8'd1;
            end
        end else begin
            starveCnt <= '0;
        end
    end

    rd_lat_pipe #(
        .RD_LAT (RD_LAT),
        .DW     (DW)
    ) uRdLatPipe (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iTag   (rdGnt),
        .iRdata (iRAM_RDATA),
        .oValid (oRVALID),
        .oData  (oRDATA)
    );

endmodule

// File: tb/tb_feat_ram_arb.sv
// Bench for feat_ram_arb: a behavioural RAM with RD_LAT read latency sits on
// the RAM port; a reference model (shadow memory, pointer/burst bookkeeping,
// queue of expected returns) predicts every output each cycle.
module tb_feat_ram_arb;

    localparam int DW        = 96;
    localparam int AW        = 8;
    localparam int RD_LAT    = 1;
    localparam int BURST_MAX = 16;

    logic          iCLK;
    logic          iRST;
    logic          iEN_WC;
    logic [AW-1:0] iWADDR;
    logic [DW-1:0] iWDATA;
    logic [1:0]    iRD_REQ;
    logic [AW-1:0] iRADDR_BWN;
    logic [AW-1:0] iRADDR_BNN;
    logic [1:0]    oRD_GNT;
    logic [1:0]    oRVALID;
    logic [DW-1:0] oRDATA;
    logic          oRAM_EN;
    logic          oRAM_WE;
    logic [AW-1:0] oRAM_ADDR;
    logic [DW-1:0] oRAM_WDATA;
    logic [DW-1:0] iRAM_RDATA;
    logic          oCOLLIDE;

    feat_ram_arb #(
        .DW        (DW),
        .AW        (AW),
        .RD_LAT    (RD_LAT),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iEN_WC     (iEN_WC),
        .iWADDR     (iWADDR),
        .iWDATA     (iWDATA),
        .iRD_REQ    (iRD_REQ),
        .iRADDR_BWN (iRADDR_BWN),
        .iRADDR_BNN (iRADDR_BNN),
        .oRD_GNT    (oRD_GNT),
        .oRVALID    (oRVALID),
        .oRDATA     (oRDATA),
        .oRAM_EN    (oRAM_EN),
        .oRAM_WE    (oRAM_WE),
        .oRAM_ADDR  (oRAM_ADDR),
        .oRAM_WDATA (oRAM_WDATA),
        .iRAM_RDATA (iRAM_RDATA),
        .oCOLLIDE   (oCOLLIDE)
    );

    // ---------------- clock ----------------
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // ---------------- behavioural RAM (environment) ----------------
    logic [DW-1:0] ramMem  [256];
    logic [DW-1:0] ramPipe [RD_LAT];

    always @(posedge iCLK) begin
        if (oRAM_EN && oRAM_WE) ramMem[oRAM_ADDR] <= oRAM_WDATA;
        ramPipe[0] <= ramMem[oRAM_ADDR];
        for (int i = 1; i < RD_LAT; i++) ramPipe[i] <= ramPipe[i-1];
    end
    assign iRAM_RDATA = ramPipe[RD_LAT-1];

    // ---------------- reference model state ----------------
    logic [DW-1:0] refMem [256];
    logic [DW+1:0] expQ [$];     // {tag, data} of reads in flight
    int            dueQ [$];     // cycle at which each return must appear
    int            cycleNum;
    int            mPri;         // 0 = BWN wins contests, 1 = BNN wins
    int            mBurst;       // contested grants in the current burst
    int            mBlocked;     // consecutive cycles a read waited on a write
    logic          mCollide;
    logic [DW-1:0] mLast;        // last returned word (held on oRDATA)

    int nCmp;
    int nErr;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cycleNum, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rndWord();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Predict and compare all outputs for the current cycle, then advance the
    // model past the coming clock edge.
    task automatic checkCycle();
        logic [1:0]    expGnt;
        logic          expEn;
        logic          expWe;
        logic [AW-1:0] expAddr;
        logic [DW+1:0] e;
        int            winner;
        expGnt  = 2'b00;
        expEn   = 1'b0;
        expWe   = 1'b0;
        expAddr = '0;
        if (iEN_WC) begin
            expEn   = 1'b1;
            expWe   = 1'b1;
            expAddr = iWADDR;
        end else if (iRD_REQ != 2'b00) begin
            expEn = 1'b1;
            if (iRD_REQ == 2'b11) winner = mPri;
            else winner = iRD_REQ[1] ? 1 : 0;
            expGnt  = (winner == 1) ? 2'b10 : 2'b01;
            expAddr = (winner == 1) ? iRADDR_BNN : iRADDR_BWN;
        end
        chk("gnt", DW'(oRD_GNT), DW'(expGnt));
        chk("ram_en", DW'(oRAM_EN), DW'(expEn));
        chk("ram_we", DW'(oRAM_WE), DW'(expWe));
        if (expEn) chk("ram_addr", DW'(oRAM_ADDR), DW'(expAddr));
        chk("ram_wdata", oRAM_WDATA, iWDATA);

        if (dueQ.size() > 0 && dueQ[0] == cycleNum) begin
            e = expQ.pop_front();
            void'(dueQ.pop_front());
            chk("rvalid", DW'(oRVALID), DW'(e[DW+1:DW]));
            chk("rdata", oRDATA, e[DW-1:0]);
            mLast = e[DW-1:0];
        end else begin
            chk("rvalid_idle", DW'(oRVALID), '0);
            chk("rdata_hold", oRDATA, mLast);
        end
        chk("collide", DW'(oCOLLIDE), DW'(mCollide));

        if (iEN_WC) refMem[iWADDR] = iWDATA;
        if (expGnt != 2'b00) begin
            expQ.push_back({expGnt, refMem[expAddr]});
            dueQ.push_back(cycleNum + RD_LAT + 1);
            if (iRD_REQ == 2'b11) begin
                mBurst++;
                if (mBurst == BURST_MAX) begin
                    mPri   = 1 - mPri;
                    mBurst = 0;
                end
            end else if (winner != mPri) begin
                mBurst = 0;
            end
        end
        if (iEN_WC && iRD_REQ != 2'b00) begin
            mBlocked++;
            if (mBlocked >= 256) mCollide = 1'b1;
        end else begin
            mBlocked = 0;
        end
        cycleNum++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic en, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [1:0] req, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        iEN_WC     = en;
        iWADDR     = wa;
        iWDATA     = wd;
        iRD_REQ    = req;
        iRADDR_BWN = ra0;
        iRADDR_BNN = ra1;
        @(negedge iCLK);
        checkCycle();
        @(posedge iCLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, rndWord(), 2'b00, '0, '0);
    endtask

    task automatic doReset();
        iRST       = 1'b1;
        iEN_WC     = 1'b0;
        iRD_REQ    = 2'b00;
        iWADDR     = '0;
        iWDATA     = '0;
        iRADDR_BWN = '0;
        iRADDR_BNN = '0;
        repeat (2) @(posedge iCLK);
        #1;
        chk("rst_rvalid", DW'(oRVALID), '0);
        chk("rst_rdata", oRDATA, '0);
        chk("rst_collide", DW'(oCOLLIDE), '0);
        iRST = 1'b0;
        mPri     = 0;
        mBurst   = 0;
        mBlocked = 0;
        mCollide = 1'b0;
        mLast    = '0;
        expQ.delete();
        dueQ.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        nCmp     = 0;
        nErr     = 0;
        cycleNum = 0;
        for (int i = 0; i < 256; i++) refMem[i] = '0;
        doReset();

        // Fill the whole RAM through the write port.
        for (int a = 0; a < 256; a++) drive(1'b1, AW'(a), rndWord(), 2'b00, '0, '0);

        // Single BWN read of address 5.
        drive(1'b0, '0, '0, 2'b01, 8'h05, '0);
        idle(1);
        chk("bwn_rd_valid", DW'(oRVALID), DW'(2'b01));
        chk("bwn_rd_data", oRDATA, refMem[5]);
        idle(2);

        // Write priority over a double read request, then BWN wins.
        drive(1'b1, 8'd10, rndWord(), 2'b11, 8'd20, 8'd30);
        drive(1'b0, '0, '0, 2'b11, 8'd20, 8'd30);
        idle(3);

        // Fairness bursts with a lone BNN request dropped into a BWN burst.
        for (int i = 0; i < 40; i++) drive(1'b0, '0, '0, 2'b11, AW'(i), AW'(i + 100));
        doReset();
        for (int i = 0; i < 5; i++) drive(1'b0, '0, '0, 2'b11, AW'(i), AW'(i + 50));
        drive(1'b0, '0, '0, 2'b10, '0, 8'd77);
        for (int i = 0; i < 40; i++) drive(1'b0, '0, '0, 2'b11, AW'(i + 7), AW'(i + 60));
        idle(3);

        // Write and BNN read of the same address in one cycle.
        drive(1'b1, 8'd3, {12{8'hA5}}, 2'b10, '0, 8'd3);
        drive(1'b0, '0, '0, 2'b10, '0, 8'd3);
        idle(1);
        chk("wr_rd_valid", DW'(oRVALID), DW'(2'b10));
        chk("wr_rd_data", oRDATA, {12{8'hA5}});
        idle(2);

        // Reset one cycle after a grant, with the pointer moved to BNN.
        doReset();
        for (int i = 0; i < BURST_MAX; i++) drive(1'b0, '0, '0, 2'b11, AW'(i), AW'(i + 1));
        drive(1'b0, '0, '0, 2'b11, 8'd1, 8'd2);
        doReset();
        idle(3);
        drive(1'b0, '0, '0, 2'b11, 8'd9, 8'd8);
        idle(3);

        // Starvation: 255 blocked cycles, a break, then 256 blocked cycles.
        for (int i = 0; i < 255; i++) drive(1'b1, AW'(i), rndWord(), 2'b01, 8'd4, '0);
        drive(1'b1, 8'd1, rndWord(), 2'b00, '0, '0);
        for (int i = 0; i < 256; i++) drive(1'b1, AW'(i), rndWord(), 2'b01, 8'd4, '0);
        idle(4);
        chk("collide_sticky", DW'(oCOLLIDE), DW'(1'b1));

        // Randomised traffic on a narrow address range to force reuse.
        doReset();
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 9) < 3), AW'($urandom_range(0, 15)), rndWord(),
                  2'($urandom_range(0, 3)), AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)));
        end
        idle(RD_LAT + 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
